// File: rtl/mips_timer.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers and a maskable interrupt.
// Build option: define MIPS_TIMER_IRQ_EN to include the irq flag, the CTRL.IM bit and o_IRQ.
module mips_timer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_Addr,
    input  logic        i_WE,
    input  logic [31:0] i_Din,
    output logic [31:0] o_Dout,
    output logic        o_IRQ
);

    typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

`ifdef MIPS_TIMER_IRQ_EN
    localparam logic [3:0] CtrlMask = 4'hF;
`else
    localparam logic [3:0] CtrlMask = 4'h7;
`endif

    state_e      state_q;
    logic [3:0]  ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        unused_addr;

    assign wr_ctrl     = i_WE && (i_Addr[3:2] == 2'd0);
    assign wr_preset   = i_WE && (i_Addr[3:2] == 2'd1);
    assign unused_addr = ^{i_Addr[31:4], i_Addr[1:0]};

    // The CTRL write sits last so it overrides the FSM's own Enable clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            ctrl_q   <= 4'h0;
            preset_q <= 32'h0;
            count_q  <= 32'h0;
        end else begin
            if (wr_preset) begin
                preset_q <= i_Din;
            end
            unique case (state_q)
                StIdle: begin
                    if (ctrl_q[0]) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    count_q <= preset_q;
                    state_q <= StCnt;
                end
                StCnt: begin
                    if (!ctrl_q[0]) begin
                        state_q <= StIdle;
                    end else if (count_q > 32'd1) begin
                        count_q <= count_q - 32'd1;
                    end else begin
                        count_q <= 32'h0;
                        state_q <= StInt;
                    end
                end
                StInt: begin
                    state_q <= StIdle;
                    if (ctrl_q[2:1] != 2'b01) begin
                        ctrl_q[0] <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (wr_ctrl) begin
                ctrl_q <= i_Din[3:0] & CtrlMask;
            end
        end
    end

`ifdef MIPS_TIMER_IRQ_EN
    logic irq_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            irq_q <= 1'b0;
        end else if (wr_ctrl) begin
            irq_q <= 1'b0;
        end else if (state_q == StCnt && ctrl_q[0] && count_q <= 32'd1) begin
            irq_q <= 1'b1;
        end else if (state_q == StInt && ctrl_q[2:1] == 2'b01) begin
            irq_q <= 1'b0;
        end
    end

    assign o_IRQ = irq_q & ctrl_q[3];
`else
    assign o_IRQ = 1'b0;
`endif

    always_comb begin
        o_Dout = 32'h0;
        unique case (i_Addr[3:2])
            2'd0:    o_Dout = {28'h0, ctrl_q};
            2'd1:    o_Dout = preset_q;
            2'd2:    o_Dout = count_q;
            default: o_Dout = 32'h0;
        endcase
    end

endmodule
